// File: rtl/spi_slave_rx_if.sv
// Pin-side and word-side signals of spi_slave_rx, bundled with modports.
// frame_err exists only when SPI_SLAVE_RX_FRAME_ERR_EN is defined.
interface spi_slave_rx_if #(
    parameter int DATA_W = 12
);
    logic              cs;
    logic              sclk;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              overrun;
    logic              busy;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic              frame_err;
`endif

    modport slave (
        input  cs, sclk, mosi, dout_ready,
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        output frame_err,
`endif
        output dout, dout_valid, overrun, busy
    );

    modport master (
        output cs, sclk, mosi, dout_ready,
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        input  frame_err,
`endif
        input  dout, dout_valid, overrun, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampling SPI receiver: LSB-first DATA_W-bit frames into a one-word valid/ready holding register.
// Define SPI_SLAVE_RX_FRAME_ERR_EN to add the frame_err pulse for short/long frames.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_rx_if.slave bus
);
    localparam int               CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill_sync;
    logic                   sclk_prev;
    logic                   armed_q;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   sample_en;

    logic [CNT_W-1:0]       count_q;
    logic [DATA_W-1:0]      shift_q;
    logic [DATA_W-1:0]      shift_d;
    logic [DATA_W-1:0]      dout_q;
    logic                   valid_q;
    logic                   overrun_q;

    logic                   busy;
    logic                   start;
    logic                   shift_en;
    logic                   load_req;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic                   short_end;
    logic                   extra_bit;
    logic                   err_seen_q;
    logic                   frame_err_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            fill_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            fill_sync <= {fill_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sample_en = sclk_prev & ~sclk_s & ~cs_s;

    // Arm only once cs is seen high through a chain holding real pin samples, not reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else if (fill_sync[SYNC_STAGES-1] && cs_s) begin
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: a default assignment before the case keeps combinational blocks latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && !cs_s) state_d = RECV;
            RECV: begin
                if (count_q == FULL) state_d = WAIT_CS;
                else if (cs_s)       state_d = IDLE;
            end
            WAIT_CS: if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        start     = (state_q == IDLE) && armed_q && !cs_s;
        shift_en  = (state_q == RECV) && (count_q != FULL) && sample_en;
        load_req  = (state_q == RECV) && (count_q == FULL);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        short_end = (state_q == RECV) && (count_q != FULL) && cs_s && (count_q != '0);
        extra_bit = (state_q == WAIT_CS) && sample_en;
`endif
    end

    assign shift_d = DATA_W'({mosi_s, shift_q} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            shift_q <= '0;
        end else if (start) begin
            count_q <= '0;
            shift_q <= '0;
        end else if (shift_en) begin
            count_q <= count_q + CNT_W'(1);
            shift_q <= shift_d;
        end
    end

    // A completed frame may load into a full register only if it is being consumed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (load_req && (!valid_q || bus.dout_ready)) begin
                dout_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (load_req) begin
                overrun_q <= 1'b1;
            end else if (valid_q && bus.dout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_seen_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= short_end || (extra_bit && !err_seen_q);
            if (start)          err_seen_q <= 1'b0;
            else if (extra_bit) err_seen_q <= 1'b1;
        end
    end

    assign bus.frame_err = frame_err_q;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx against a frame-level reference model (queue of expected words).
module tb_spi_slave_rx;
    localparam int DATA_W = 12;
    localparam int SYNC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    spi_slave_rx_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          cyc         = 0;
    int          checks      = 0;
    int          errors      = 0;
    int          ovr_cnt     = 0;
    int          ferr_cnt    = 0;
    int          falls       = 0;
    int          fall_cyc    = 0;
    int          valid_cyc   = 0;
    int          vcnt        = 0;
    bit          mon_en      = 1'b0;
    bit          rand_rdy    = 1'b0;
    bit          ready_fixed = 1'b1;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits, input int half,
                              input bit end_cs);
        falls   = 0;
        bus.cs  = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nbits; i++) begin
            bus.sclk = 1'b1;
            bus.mosi = data[i];
            wait_clk(half);
            bus.sclk = 1'b0;
            fall_cyc = cyc;
            falls    = falls + 1;
            wait_clk(half);
        end
        if (end_cs) begin
            bus.cs = 1'b1;
            wait_clk(half < 6 ? 6 : half);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            vcnt           = bus.dout_valid ? vcnt + 1 : 0;
            bus.dout_ready = ($urandom_range(0, 3) == 0) || (vcnt >= 6);
        end else begin
            bus.dout_ready = ready_fixed;
        end
    end

    always @(negedge clk) begin
        if (bus.overrun === 1'b1) ovr_cnt++;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        if (bus.frame_err === 1'b1) ferr_cnt++;
`endif
        if (mon_en && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
            valid_cyc = cyc;
            if (exp_q.size() == 0) check("spurious_word", 32'(bus.dout), 32'hFFFF_FFFF);
            else                   check("word", 32'(bus.dout), exp_q.pop_front());
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int f0;
        int n;
        int half;
        int exp_err;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] data;

        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        #1;
        check("rst_dout",    32'(bus.dout),       32'h0);
        check("rst_valid",   32'(bus.dout_valid), 32'h0);
        check("rst_overrun", 32'(bus.overrun),    32'h0);
        check("rst_busy",    32'(bus.busy),       32'h0);
        wait_clk(4);
        rst = 1'b0;
        wait_clk(6);

        // Single frame, latency from final falling edge
        mon_en = 1'b1;
        o0 = ovr_cnt;
        exp_q.push_back(32'hA5C);
        send_frame(32'hA5C, 12, 11, 1'b1);
        wait_clk(10);
        check("t1_latency", 32'(valid_cyc - fall_cyc), 32'(SYNC + 2));
        check("t1_drained", 32'(exp_q.size()), 32'h0);
        check("t1_overrun", 32'(ovr_cnt - o0), 32'h0);

        // Two frames without consumer: first held, second dropped
        mon_en      = 1'b0;
        ready_fixed = 1'b0;
        wait_clk(2);
        o0 = ovr_cnt;
        send_frame(32'h001, 12, 6, 1'b1);
        send_frame(32'h800, 12, 6, 1'b1);
        wait_clk(4);
        check("t2_dout_held", 32'(bus.dout),       32'h001);
        check("t2_valid",     32'(bus.dout_valid), 32'h1);
        check("t2_overrun",   32'(ovr_cnt - o0),   32'h1);
        ready_fixed = 1'b1;
        wait_clk(1);
        check("t2_valid_pre", 32'(bus.dout_valid), 32'h1);
        wait_clk(1);
        check("t2_valid_clr", 32'(bus.dout_valid), 32'h0);
        check("t2_dout_keep", 32'(bus.dout),       32'h001);

        // Short frame then full frame
        mon_en = 1'b1;
        f0 = ferr_cnt;
        exp_q.push_back(32'h3C3);
        send_frame(32'h0D, 5, 8, 1'b1);
        send_frame(32'h3C3, 12, 8, 1'b1);
        wait_clk(6);
        check("t3_drained", 32'(exp_q.size()), 32'h0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check("t3_frame_err", 32'(ferr_cnt - f0), 32'h1);
`endif

        // Long frame: extra bits ignored
        f0 = ferr_cnt;
        exp_q.push_back(32'hFFF);
        send_frame(32'h3FFF, 14, 7, 1'b1);
        wait_clk(6);
        check("t4_drained", 32'(exp_q.size()), 32'h0);
        check("t4_dout",    32'(bus.dout),     32'hFFF);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check("t4_frame_err", 32'(ferr_cnt - f0), 32'h1);
`endif

        // Reset mid-frame with cs held low across release
        f0 = ferr_cnt;
        send_frame(32'h555, 6, 5, 1'b0);
        check("t5_busy_pre", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_dout",  32'(bus.dout),       32'h0);
        check("t5_rst_valid", 32'(bus.dout_valid), 32'h0);
        check("t5_rst_busy",  32'(bus.busy),       32'h0);
        wait_clk(3);
        rst = 1'b0;
        send_frame(32'hABC, 12, 5, 1'b1);
        exp_q.push_back(32'h0F0);
        send_frame(32'h0F0, 12, 5, 1'b1);
        wait_clk(6);
        check("t5_drained", 32'(exp_q.size()), 32'h0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check("t5_frame_err", 32'(ferr_cnt - f0), 32'h0);
`endif

        // Load and accept in the same cycle
        mon_en      = 1'b0;
        ready_fixed = 1'b0;
        w1 = 32'($urandom_range(0, 4095));
        w2 = 32'($urandom_range(0, 4095));
        wait_clk(2);
        send_frame(w1, 12, 6, 1'b1);
        check("t6_first", 32'(bus.dout), w1);
        o0 = ovr_cnt;
        fork
            send_frame(w2, 12, 6, 1'b1);
            begin
                wait (falls == 12);
                wait_clk(2);
                ready_fixed = 1'b1;
                wait_clk(1);
                ready_fixed = 1'b0;
                wait_clk(1);
                check("t6_dout",  32'(bus.dout),       w2);
                check("t6_valid", 32'(bus.dout_valid), 32'h1);
            end
        join
        check("t6_overrun", 32'(ovr_cnt - o0), 32'h0);
        ready_fixed = 1'b1;
        wait_clk(3);
        check("t6_valid_clr", 32'(bus.dout_valid), 32'h0);

        // Randomised frames of random length, rate and consumer back-pressure
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        o0       = ovr_cnt;
        f0       = ferr_cnt;
        exp_err  = 0;
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    n = $urandom_range(1, DATA_W - 1);
                2, 3:    n = $urandom_range(DATA_W + 1, DATA_W + 3);
                default: n = DATA_W;
            endcase
            half = $urandom_range(4, 12);
            data = $urandom;
            if (n >= DATA_W) exp_q.push_back(data & 32'hFFF);
            if (n != DATA_W) exp_err++;
            send_frame(data, n, half, 1'b1);
            wait_clk($urandom_range(0, 8));
        end
        wait_clk(40);
        check("rnd_drained", 32'(exp_q.size()), 32'h0);
        check("rnd_overrun", 32'(ovr_cnt - o0), 32'h0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check("rnd_frame_err", 32'(ferr_cnt - f0), 32'(exp_err));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side stage that consumes the cs/sclk/mosi stream produced by the team's SPI master.
- Runs entirely in the system clk domain: synchronises and oversamples cs, sclk and mosi, then deserialises LSB-first frames of DATA_W bits.
- Presents each completed word on a valid/ready output interface to downstream logic; a one-word holding register provides buffering.
- Sits between the SPI pins and the word-level consumer; used as the bench-side reference receiver for the master and as a standalone slave.

Parameters:
- DATA_W, 12, bits per frame; legal range 1 to 32.
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 2 to 3.

Ports:
- clk  input  1  system clock; sclk must be at most clk/8.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  chip select, active low, asynchronous to clk.
- sclk  input  1  serial clock, asynchronous to clk.
- mosi  input  1  serial data, asynchronous to clk; the master changes it on sclk rising edges.
- dout  output  DATA_W  received word, LSB received first; stable while dout_valid is high.
- dout_valid  output  1  holding register holds an unconsumed word.
- dout_ready  input  1  consumer accepts the word when dout_valid and dout_ready are both high at a clk rising edge.
- overrun  output  1  one-clk pulse when a completed frame is dropped because the holding register is still full.
- busy  output  1  high while in RECV or WAIT_CS.

Behaviour:
- Reset values (rst asserted, asynchronous): dout=0, dout_valid=0, overrun=0, busy=0, bit counter=0, shift register=0, FSM=IDLE.
- Synchroniser reset values: cs chain resets to 1; sclk and mosi chains reset to 0.
- Input path: cs, sclk and mosi each pass through SYNC_STAGES flops. One additional flop on synced sclk gives edge detect.
- sample_en: one-clk strobe on a detected sclk falling edge (previous 1, current 0). Sampling on the falling edge centres the sample in the bit period.
- FSM state IDLE:
  - busy=0.
  - Synced cs=0 → RECV; bit counter cleared.
- FSM state RECV:
  - Each sample_en shifts synced mosi into the shift register, LSB-first (bit n lands at position n) and increments the counter.
  - When the counter reaches DATA_W, on the same clk: attempt load, then → WAIT_CS.
  - Synced cs=1 before DATA_W bits (short frame): discard partial data → IDLE; no output change.
- FSM state WAIT_CS:
  - Further sample_en strobes are ignored; extra bits are discarded.
  - Synced cs=1 → IDLE.
- Load rules:
  - If dout_valid=0, or a dout_valid&&dout_ready handshake occurs in the same cycle: dout takes the shift value and dout_valid=1.
  - Otherwise: word dropped, dout unchanged, overrun pulses high for exactly 1 clk.
- Handshake:
  - dout_valid&&dout_ready with no simultaneous load → dout_valid=0 next cycle.
  - dout holds its value until the next load.
- Latency: the final sampling sclk falling edge reaches dout_valid=1 in SYNC_STAGES+2 clk cycles.
- sclk edges while synced cs=1 are ignored.
- Reset mid-frame: all state clears immediately. The first frame after reset release is accepted only after synced cs is seen high and then low.
- cs held low across multiple frames is not supported; each frame requires a cs high period of at least 2 clk.

Optional Feature:
- Macro: SPI_SLAVE_RX_FRAME_ERR_EN.
- Defined:
  - Adds output port frame_err (1 bit, reset 0).
  - frame_err pulses for 1 clk when cs deasserts in RECV with 0 < count < DATA_W.
  - frame_err also pulses when a sample_en arrives in WAIT_CS (too many bits); at most one pulse per frame.
- Undefined: port absent; short and long frames are handled silently as described above.

Test Plan:
- Single frame 12'hA5C, LSB-first, sclk=clk/22, dout_ready=1 → one dout_valid pulse with dout=12'hA5C, within 4 clk of the 12th sclk falling edge.
- Two back-to-back frames 12'h001 then 12'h800, dout_ready=0 throughout → dout=12'h001 held, dout_valid stays 1, overrun pulses once at second-frame completion; raising dout_ready clears dout_valid next cycle.
- Short frame: cs low for 5 bits (1,0,1,1,0) then high, followed by full frame 12'h3C3 → only 12'h3C3 is delivered; with the macro defined, frame_err pulses once at the cs rise.
- Long frame: 14 bits with the first 12 equal to 12'hFFF → dout=12'hFFF and the 2 extra bits ignored; with the macro defined, one frame_err pulse.
- rst asserted at bit 6 of frame 12'h555, released, then frame 12'h0F0 → outputs return to 0 immediately on reset; only 12'h0F0 is delivered.
- Load and accept in the same cycle: hold dout_ready=1 exactly on the completion cycle of frame 2 while frame 1 is valid → dout=frame 2, dout_valid stays 1, no overrun.
